// File: rtl/cpu_subsys_bus_decoder.sv
// Address decoder and response mux from the CPU native memory port to SRAM and peripheral bus,
// with error responses for unmapped addresses and target timeouts. Optional: CPU_SUBSYS_BUS_ERR_STICKY_EN.
module cpu_subsys_bus_decoder #(
    parameter logic [15:0] SRAM_BASE      = 16'h0000,
    parameter logic [15:0] PERIPH_BASE    = 16'h1000,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic [31:0] tgt_addr,
    output logic [31:0] tgt_wdata,
    output logic [3:0]  tgt_wstrb,
    output logic        sram_valid,
    input  logic        sram_ready,
    input  logic [31:0] sram_rdata,
    output logic        periph_valid,
    input  logic        periph_ready,
    input  logic [31:0] periph_rdata,
`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
    output logic [31:0] err_addr,
    input  logic        err_clr,
`endif
    output logic        bus_err
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_SRAM   = 2'd1,
        WAIT_PERIPH = 2'd2,
        RESP        = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          ready_reg;
    logic          err_reg;
    logic          err_next;

    assign tgt_addr  = mem_addr;
    assign tgt_wdata = mem_wdata;
    assign tgt_wstrb = mem_wstrb;

    // State register; response flags are registered so the CPU sees clean pulses in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            ready_reg <= (state_next == RESP);
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_addr[31:16] == SRAM_BASE) begin
                        state_next = WAIT_SRAM;
                        cnt_next   = '0;
                    end else if (mem_addr[31:16] == PERIPH_BASE) begin
                        state_next = WAIT_PERIPH;
                        cnt_next   = '0;
                    end else begin
                        state_next = RESP;
                        rdata_next = ERR_RDATA;
                        err_next   = 1'b1;
                    end
                end
            end
            WAIT_SRAM: begin
                // A ready coinciding with the last wait cycle still wins.
                if (sram_ready) begin
                    state_next = RESP;
                    rdata_next = sram_rdata;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT_PERIPH: begin
                if (periph_ready) begin
                    state_next = RESP;
                    rdata_next = periph_rdata;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = RESP;
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        sram_valid   = (state_reg == WAIT_SRAM);
        periph_valid = (state_reg == WAIT_PERIPH);
        mem_ready    = ready_reg;
        bus_err      = err_reg;
        mem_rdata    = rdata_reg;
    end

`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
    logic [31:0] err_addr_reg;
    logic        sticky_reg;

    // A clear in the same cycle as a new error re-arms capture for that error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_reg <= '0;
            sticky_reg   <= 1'b0;
        end else if (err_next && (!sticky_reg || err_clr)) begin
            err_addr_reg <= mem_addr;
            sticky_reg   <= 1'b1;
        end else if (err_clr) begin
            sticky_reg <= 1'b0;
        end
    end

    assign err_addr = err_addr_reg;
`endif

endmodule

// File: tb/tb_cpu_subsys_bus_decoder.sv
// Table-driven bench for cpu_subsys_bus_decoder with SRAM and peripheral models;
// covers CPU_SUBSYS_BUS_ERR_STICKY_EN when that macro is defined.
`timescale 1ns/1ps
module tb_cpu_subsys_bus_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic [31:0] tgt_addr;
    logic [31:0] tgt_wdata;
    logic [3:0]  tgt_wstrb;
    logic        sram_valid;
    logic        sram_ready;
    logic [31:0] sram_rdata;
    logic        periph_valid;
    logic        periph_ready;
    logic [31:0] periph_rdata;
    logic        bus_err;
`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
    logic [31:0] err_addr;
    logic        err_clr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_subsys_bus_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .tgt_addr     (tgt_addr),
        .tgt_wdata    (tgt_wdata),
        .tgt_wstrb    (tgt_wstrb),
        .sram_valid   (sram_valid),
        .sram_ready   (sram_ready),
        .sram_rdata   (sram_rdata),
        .periph_valid (periph_valid),
        .periph_ready (periph_ready),
        .periph_rdata (periph_rdata),
`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
        .err_addr     (err_addr),
        .err_clr      (err_clr),
`endif
        .bus_err      (bus_err)
    );

    // SRAM model: ready in the first cycle of sram_valid, byte-strobed writes.
    logic [31:0] sram_mem [0:255];
    logic        sram_hold;
    logic        mem_clr;
    assign sram_ready = sram_valid && !sram_hold;
    assign sram_rdata = sram_mem[tgt_addr[9:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= 32'h0;
        end else if (sram_ready && tgt_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (tgt_wstrb[b]) sram_mem[tgt_addr[9:2]][8*b +: 8] <= tgt_wdata[8*b +: 8];
        end
    end

    // Peripheral model: ready in the periph_delay-th cycle of periph_valid (0 = never).
    int          periph_delay;
    int          periph_cnt;
    logic        periph_force;
    logic [31:0] periph_data;
    assign periph_rdata = periph_data;
    assign periph_ready = periph_force ||
                          (periph_valid && periph_delay != 0 && periph_cnt == periph_delay - 1);

    always @(posedge clk) begin
        if (periph_valid) periph_cnt <= periph_cnt + 1;
        else              periph_cnt <= 0;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          pdelay;
        logic        pforce;
        logic [31:0] pdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        exp_sv;
        logic        exp_pv;
        int          exp_pvc;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Latency = clock edges from the edge that samples mem_valid to the edge that samples mem_ready.
    task automatic run_access(input vec_t v, input int idx);
        int          lat;
        int          pvc;
        logic        got;
        logic        sv;
        logic        pv;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        periph_delay = v.pdelay;
        periph_force = v.pforce;
        periph_data  = v.pdata;
        mem_addr     = v.addr;
        mem_wdata    = v.wdata;
        mem_wstrb    = v.wstrb;
        mem_valid    = 1'b1;
        lat = 0; pvc = 0; got = 1'b0; sv = 1'b0; pv = 1'b0; rd = '0; er = 1'b0;
        while (!got && lat < 400) begin
            if (sram_valid) sv = 1'b1;
            if (periph_valid) begin pv = 1'b1; pvc++; end
            @(negedge clk);
            lat++;
            if (mem_ready) begin got = 1'b1; rd = mem_rdata; er = bus_err; end
        end
        mem_valid    = 1'b0;
        mem_wstrb    = 4'h0;
        periph_force = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL v%0d ready_timeout: got no mem_ready in %0d cycles expected one", idx, lat);
        end else begin
            chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
            chk($sformatf("v%0d bus_err", idx), 32'(er), 32'(v.exp_err));
            chk($sformatf("v%0d latency", idx), 32'(lat + 1), 32'(v.exp_lat));
            chk($sformatf("v%0d sram_valid_seen", idx), 32'(sv), 32'(v.exp_sv));
            chk($sformatf("v%0d periph_valid_seen", idx), 32'(pv), 32'(v.exp_pv));
            chk($sformatf("v%0d periph_valid_cycles", idx), 32'(pvc), 32'(v.exp_pvc));
        end
        @(negedge clk);
        chk($sformatf("v%0d single_pulse", idx), {30'b0, mem_ready, bus_err}, 32'h0);
        $display("v%0d addr=0x%08h wstrb=%h rdata=0x%08h err=%0d latency=%0d", idx, v.addr, v.wstrb, rd, er, lat + 1);
    endtask

    initial begin
        logic seen;
        //        addr           wdata          wstrb  pdly pf   pdata          exp_rdata      err lat  sv   pv   pvc
        vecs[0]  = '{32'h0000_0010, 32'hA5A5_1234, 4'hF, 0,   1'b0, 32'h0,         32'h0000_0000, 1'b0, 3,   1'b1, 1'b0, 0};
        vecs[1]  = '{32'h0000_0010, 32'h0,         4'h0, 0,   1'b0, 32'h0,         32'hA5A5_1234, 1'b0, 3,   1'b1, 1'b0, 0};
        vecs[2]  = '{32'h1000_0004, 32'h0,         4'h0, 5,   1'b0, 32'h0000_00C3, 32'h0000_00C3, 1'b0, 7,   1'b0, 1'b1, 5};
        vecs[3]  = '{32'h2000_0000, 32'h0,         4'h0, 0,   1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 2,   1'b0, 1'b0, 0};
        vecs[4]  = '{32'h1000_0008, 32'h0,         4'h0, 0,   1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 1'b1, 258, 1'b0, 1'b1, 256};
        vecs[5]  = '{32'h0000_0010, 32'h0,         4'h0, 0,   1'b0, 32'h0,         32'hA5A5_1234, 1'b0, 3,   1'b1, 1'b0, 0};
        vecs[6]  = '{32'h1000_000C, 32'h0,         4'h0, 256, 1'b0, 32'h5A5A_0001, 32'h5A5A_0001, 1'b0, 258, 1'b0, 1'b1, 256};
        vecs[7]  = '{32'h0000_0014, 32'h1122_3344, 4'h3, 0,   1'b0, 32'h0,         32'h0000_0000, 1'b0, 3,   1'b1, 1'b0, 0};
        vecs[8]  = '{32'h0000_0014, 32'h0,         4'h0, 0,   1'b0, 32'h0,         32'h0000_3344, 1'b0, 3,   1'b1, 1'b0, 0};
        vecs[9]  = '{32'h0000_0010, 32'h0,         4'h0, 0,   1'b1, 32'h7777_7777, 32'hA5A5_1234, 1'b0, 3,   1'b1, 1'b0, 0};
        vecs[10] = '{32'h0001_0000, 32'h0,         4'h0, 0,   1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 2,   1'b0, 1'b0, 0};
        vecs[11] = '{32'h0000_FFFC, 32'h0,         4'h0, 0,   1'b0, 32'h0,         32'h0000_0000, 1'b0, 3,   1'b1, 1'b0, 0};

        rst = 1'b1; mem_clr = 1'b1; sram_hold = 1'b0;
        mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        periph_delay = 0; periph_force = 1'b0; periph_data = '0;
`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset mem_ready", 32'(mem_ready), 32'h0);
        chk("reset mem_rdata", mem_rdata, 32'h0);
        chk("reset bus_err", 32'(bus_err), 32'h0);
        chk("reset valids", {30'b0, sram_valid, periph_valid}, 32'h0);
`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
        chk("reset err_addr", err_addr, 32'h0);
`endif
        rst = 1'b0; mem_clr = 1'b0;

        for (int i = 0; i < 12; i++) run_access(vecs[i], i);

        // Reset in the middle of an SRAM wait: everything drops at once, no response follows.
        sram_hold = 1'b1;
        @(negedge clk);
        mem_addr = 32'h0000_0020; mem_wstrb = 4'h0; mem_valid = 1'b1;
        @(negedge clk);
        chk("midrst sram_valid_before", 32'(sram_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst valids", {30'b0, sram_valid, periph_valid}, 32'h0);
        chk("midrst ready_err", {30'b0, mem_ready, bus_err}, 32'h0);
        chk("midrst mem_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0; mem_valid = 1'b0; sram_hold = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
        end
        chk("midrst no_ready", 32'(seen), 32'h0);
        $display("midrst sequence done");
        run_access(vecs[1], 12);

`ifdef CPU_SUBSYS_BUS_ERR_STICKY_EN
        vecs[3].addr = 32'h3000_0000;
        run_access(vecs[3], 13);
        chk("sticky first", err_addr, 32'h3000_0000);
        vecs[3].addr = 32'h4000_0000;
        run_access(vecs[3], 14);
        chk("sticky held", err_addr, 32'h3000_0000);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vecs[3].addr = 32'h5000_0000;
        run_access(vecs[3], 15);
        chk("sticky after_clr", err_addr, 32'h5000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
